// File: rtl/cplx_mul_pipe.sv
// Pipelined signed fixed-point complex multiplier (twiddle stage) with valid/ready
// flow control, per-sample conjugate, sideband tag and sticky saturation flag.
module cplx_mul_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int FRAC   = TW_W - 1,
  parameter int TAG_W  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic signed [DATA_W-1:0] io_op1_re,
  input  logic signed [DATA_W-1:0] io_op1_im,
  input  logic signed [TW_W-1:0]   io_op2_re,
  input  logic signed [TW_W-1:0]   io_op2_im,
  input  logic                     io_conj,
  input  logic [TAG_W-1:0]         io_tag_in,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic signed [DATA_W-1:0] io_res_re,
  output logic signed [DATA_W-1:0] io_res_im,
  output logic [TAG_W-1:0]         io_tag_out,
  output logic                     io_sat,
  output logic                     io_sat_sticky,
  input  logic                     io_sat_clear
);

  localparam int P_W = DATA_W + TW_W;
  localparam int S_W = P_W + 1;
  localparam int R_W = S_W + 1;

  localparam logic signed [R_W-1:0] RND =
    (FRAC > 0) ? R_W'(1) << ((FRAC > 0) ? FRAC - 1 : 0) : '0;
  localparam logic signed [R_W-1:0] MAXV = {{(R_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] MINV = ~MAXV;

  // S1: input capture
  logic                     s1_v_q, s1_v_d;
  logic signed [DATA_W-1:0] s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
  logic signed [TW_W-1:0]   s1_b_re_q, s1_b_re_d, s1_b_im_q, s1_b_im_d;
  logic                     s1_conj_q, s1_conj_d;
  logic [TAG_W-1:0]         s1_tag_q, s1_tag_d;

  // S2: full-width partial products
  logic                     s2_v_q, s2_v_d;
  logic signed [P_W-1:0]    s2_prr_q, s2_prr_d, s2_pii_q, s2_pii_d;
  logic signed [P_W-1:0]    s2_pri_q, s2_pri_d, s2_pir_q, s2_pir_d;
  logic                     s2_conj_q, s2_conj_d;
  logic [TAG_W-1:0]         s2_tag_q, s2_tag_d;

  // S3: output registers
  logic                     out_v_q, out_v_d;
  logic signed [DATA_W-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic                     sat_q, sat_d;
  logic                     sticky_q, sticky_d;

  logic                     adv;
  logic signed [S_W-1:0]    re_sum, im_sum;
  logic [DATA_W:0]          re_rs, im_rs;

  // Returns {clamped, value}: round half up, arithmetic shift, clamp to DATA_W.
  function automatic logic [DATA_W:0] round_sat(input logic signed [S_W-1:0] s);
    logic signed [R_W-1:0] r;
    r = (R_W'(s) + RND) >>> FRAC;
    if (r > MAXV)      round_sat = {1'b1, MAXV[DATA_W-1:0]};
    else if (r < MINV) round_sat = {1'b1, MINV[DATA_W-1:0]};
    else               round_sat = {1'b0, r[DATA_W-1:0]};
  endfunction

  assign adv         = !out_v_q || io_out_ready;
  assign io_in_ready = adv;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_re_d = s1_a_re_q;
    s1_a_im_d = s1_a_im_q;
    s1_b_re_d = s1_b_re_q;
    s1_b_im_d = s1_b_im_q;
    s1_conj_d = s1_conj_q;
    s1_tag_d  = s1_tag_q;
    if (adv) begin
      s1_v_d    = io_in_valid;
      s1_a_re_d = io_op1_re;
      s1_a_im_d = io_op1_im;
      s1_b_re_d = io_op2_re;
      s1_b_im_d = io_op2_im;
      s1_conj_d = io_conj;
      s1_tag_d  = io_tag_in;
    end
  end

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_prr_d  = s2_prr_q;
    s2_pii_d  = s2_pii_q;
    s2_pri_d  = s2_pri_q;
    s2_pir_d  = s2_pir_q;
    s2_conj_d = s2_conj_q;
    s2_tag_d  = s2_tag_q;
    if (adv) begin
      s2_v_d    = s1_v_q;
      s2_prr_d  = P_W'(s1_a_re_q) * P_W'(s1_b_re_q);
      s2_pii_d  = P_W'(s1_a_im_q) * P_W'(s1_b_im_q);
      s2_pri_d  = P_W'(s1_a_re_q) * P_W'(s1_b_im_q);
      s2_pir_d  = P_W'(s1_a_im_q) * P_W'(s1_b_re_q);
      s2_conj_d = s1_conj_q;
      s2_tag_d  = s1_tag_q;
    end
  end

  always_comb begin
    if (s2_conj_q) begin
      re_sum = S_W'(s2_prr_q) + S_W'(s2_pii_q);
      im_sum = S_W'(s2_pir_q) - S_W'(s2_pri_q);
    end else begin
      re_sum = S_W'(s2_prr_q) - S_W'(s2_pii_q);
      im_sum = S_W'(s2_pri_q) + S_W'(s2_pir_q);
    end
    re_rs = round_sat(re_sum);
    im_rs = round_sat(im_sum);
  end

  // Output data only reloads on a real sample so bubbles leave the last result visible.
  always_comb begin
    out_v_d  = out_v_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    tag_d    = tag_q;
    sat_d    = sat_q;
    if (adv) begin
      out_v_d = s2_v_q;
      if (s2_v_q) begin
        res_re_d = re_rs[DATA_W-1:0];
        res_im_d = im_rs[DATA_W-1:0];
        tag_d    = s2_tag_q;
        sat_d    = re_rs[DATA_W] | im_rs[DATA_W];
      end
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (adv && s2_v_q && (re_rs[DATA_W] | im_rs[DATA_W])) sticky_d = 1'b1;
    else if (io_sat_clear)                                sticky_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_v_q    <= 1'b0;
      s1_a_re_q <= '0;
      s1_a_im_q <= '0;
      s1_b_re_q <= '0;
      s1_b_im_q <= '0;
      s1_conj_q <= 1'b0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_prr_q  <= '0;
      s2_pii_q  <= '0;
      s2_pri_q  <= '0;
      s2_pir_q  <= '0;
      s2_conj_q <= 1'b0;
      s2_tag_q  <= '0;
      out_v_q   <= 1'b0;
      res_re_q  <= '0;
      res_im_q  <= '0;
      tag_q     <= '0;
      sat_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_re_q <= s1_a_re_d;
      s1_a_im_q <= s1_a_im_d;
      s1_b_re_q <= s1_b_re_d;
      s1_b_im_q <= s1_b_im_d;
      s1_conj_q <= s1_conj_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      s2_prr_q  <= s2_prr_d;
      s2_pii_q  <= s2_pii_d;
      s2_pri_q  <= s2_pri_d;
      s2_pir_q  <= s2_pir_d;
      s2_conj_q <= s2_conj_d;
      s2_tag_q  <= s2_tag_d;
      out_v_q   <= out_v_d;
      res_re_q  <= res_re_d;
      res_im_q  <= res_im_d;
      tag_q     <= tag_d;
      sat_q     <= sat_d;
      sticky_q  <= sticky_d;
    end
  end

  assign io_out_valid  = out_v_q;
  assign io_res_re     = res_re_q;
  assign io_res_im     = res_im_q;
  assign io_tag_out    = tag_q;
  assign io_sat        = sat_q;
  assign io_sat_sticky = sticky_q;

endmodule
